// File: rtl/booth_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : booth_dot_acc
// Purpose  : Dot-product accumulation stage fed by the Booth multiplier.
//            Accepts a programmed number of signed products over a
//            valid/ready handshake and sums them into a wide two's-complement
//            accumulator that saturates instead of wrapping. When the count
//            is reached, the result is offered on an output handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start_i      in   1      begin a run (only looked at in IDLE)
//   len_i        in   LEN_W  number of products in the run, taken with start_i
//   p_valid_i    in   1      product available
//   p_ready_o    out  1      product accepted this cycle when p_valid_i high
//   p_data_i     in   PW     signed product
//   acc_valid_o  out  1      result available
//   acc_ready_i  in   1      downstream takes the result
//   acc_data_o   out  AW     signed accumulated result
//   ovf_o        out  1      saturation seen in the current or last run
//   busy_o       out  1      a run is in progress or its result is pending
// ============================================================================
module booth_dot_acc #(
    parameter int N     = 16,
    parameter int PW    = 2 * (N + 1),
    parameter int AW    = PW + 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             p_valid_i,
    output logic             p_ready_o,
    input  logic [PW-1:0]    p_data_i,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic [AW-1:0]    acc_data_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] C_ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] C_ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q,   acc_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    // One guard bit above the accumulator: the true sum of two in-range
    // values always fits, so overflow shows up as the top two bits differing.
    logic [AW:0]      w_sum;
    logic             w_sat_hit;
    logic [AW-1:0]    w_sat;

    assign w_sum     = {acc_q[AW-1], acc_q}
                     + {{(AW + 1 - PW){p_data_i[PW-1]}}, p_data_i};
    assign w_sat_hit = w_sum[AW] ^ w_sum[AW-1];
    // Guard bit carries the true sign: 0 means positive overflow.
    assign w_sat     = !w_sat_hit  ? w_sum[AW-1:0] :
                       !w_sum[AW]  ? C_ACC_MAX     : C_ACC_MIN;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACC: begin
                // p_ready is high throughout ACC, so p_valid alone marks a handshake.
                if (p_valid_i) begin
                    acc_d = w_sat;
                    if (w_sat_hit) begin
                        ovf_d = 1'b1;
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output is a decode of registered state, never of an input.
    assign p_ready_o   = (state_q == S_ACC);
    assign acc_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign acc_data_o  = acc_q;
    assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: doc/booth_dot_acc.md
# booth_dot_acc

Downstream accumulation stage for the parameterised Booth multiplier. It consumes a stream of signed products over a valid/ready handshake and sums a programmed number of them into a wide saturating accumulator. When the count is reached, it presents the dot-product result on an output handshake. Its product input width matches the multiplier's `2*(N+1)`-bit output, so the multiplier output connects directly, through a product register, to `p_data`.

## Interface
Parameters:
- `N`, default 16: operand width of the upstream multiplier.
- `PW`, default `2*(N+1)`: product width, two's complement.
- `AW`, default `PW+8`: accumulator width, two's complement.
- `LEN_W`, default 8: width of the product-count field.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin a new run. Sampled only in IDLE.
- `len`, in, LEN_W: number of products in the run. Sampled with `start`.
- `p_valid`, in, 1: product available.
- `p_ready`, out, 1: block accepts a product.
- `p_data`, in, PW: signed product.
- `acc_valid`, out, 1: result available.
- `acc_ready`, in, 1: downstream accepts the result.
- `acc_data`, out, AW: signed accumulated result.
- `ovf`, out, 1: saturation occurred during the current or last run.
- `busy`, out, 1: state is not IDLE.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `p_ready=0`, `acc_valid=0`.
  - `start=1` and `len!=0`: `acc<=0`, `cnt<=len`, `ovf<=0`, go to ACC.
  - `start=1` and `len==0`: `acc<=0`, `ovf<=0`, go directly to DONE.
- ACC:
  - `p_ready=1`.
  - On handshake (`p_valid & p_ready`): sign-extend `p_data` to AW+1 bits and add it to `acc`. Decrement `cnt`.
  - If the handshake occurs with `cnt==1`, go to DONE.
- DONE:
  - `p_ready=0`, `acc_valid=1`, `acc_data=acc`.
  - On `acc_ready`, go to IDLE. `acc_data` and `ovf` hold their values until the next accepted `start`.
- Saturation:
  - The sum is computed at AW+1 bits.
  - If the sum is above `2^(AW-1)-1`, clamp to that value. If it is below `-2^(AW-1)`, clamp to that value.
  - In either case set `ovf`. `ovf` is sticky for the run.
  - Later products keep adding onto the clamped value, with saturation applied again.
- `start` outside IDLE is ignored. `len` is not re-sampled mid-run.
- `busy = (state != IDLE)`.
- `p_data` is consumed only on a handshake. A stalled `p_valid` leaves `acc` and `cnt` unchanged.

## Timing
- Reset (async assert, sync release): state=IDLE, `acc=0`, `cnt=0`, `acc_data=0`, `ovf=0`, `p_ready=0`, `acc_valid=0`, `busy=0`.
- Reset mid-run aborts immediately. The partial sum is discarded and no `acc_valid` follows.
- `start` accepted on edge k: `busy=1` and `p_ready=1` from cycle k+1.
- Throughput: one product per cycle when `p_valid` is held high.
- Final handshake on edge t: `acc_valid=1` from cycle t+1, carrying the sum that includes that last product.
- `acc_valid` stays high until `acc_ready`. On the accepting edge the state returns to IDLE and `acc_valid` drops.
- `start` is honoured at the earliest on the edge after return to IDLE. Minimum run gap is one idle cycle.
- `len==0`: `acc_valid=1` one cycle after `start`, with `acc_data=0`.
- All outputs are registered or decoded from registered state. There is no combinational path from `p_valid` or `acc_ready` to any output.

## Test plan
- **Basic dot product.** N=16, `len=3`, products 2^0·2^0, 2^15·2^1, 2^3·2^4 (1, 65536, 128) presented back-to-back.
  - Expect `acc_valid` one cycle after the third handshake, `acc_data=65665`, `ovf=0`.
- **Signed sum and stalls.** `len=4`, products +100, −250, +30, −5 with `p_valid` gapped by 2 idle cycles between items.
  - Expect `acc_data=−125`, `ovf=0`, and 4 handshakes only.
- **Saturation.** Instance with `AW=35`, `len=3`, `p_data=2^33−1` three times.
  - After the 2nd item `acc=2^34−2`. Final `acc_data=2^34−1`, `ovf=1`.
  - Repeat with `−2^33` four times: expect `acc_data=−2^34`, `ovf=1`.
- **Zero length and ignored start.**
  - `len=0`: expect `acc_valid` on the next cycle with `acc_data=0`.
  - Pulsing `start` with `len=5` while in ACC or DONE leaves `cnt` and the result unaffected.
- **Output backpressure.** Hold `acc_ready=0` for 10 cycles after `acc_valid`.
  - Expect `acc_data` stable, `p_ready=0`, `busy=1`. IDLE entered on the edge after `acc_ready=1`.
- **Reset mid-run.** `len=5`, assert `rst_n=0` after 2 handshakes.
  - Expect all outputs 0 immediately, state IDLE, and no `acc_valid`.
  - A fresh `len=1` run with `p_data=7` then yields `acc_data=7`.
